shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Load/shift/done sequencer that drives a downstream parallel-load shift register.
// Optional macro SHIFT_SEQ_CNT_EN adds a per-sequence shift_len input (default: fixed 8 shifts).
module shift_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       dir_in,
`ifdef SHIFT_SEQ_CNT_EN
    input  logic [3:0] shift_len,
`endif
    output logic       data_ready,
    output logic [7:0] i,
    output logic       load_enable,
    output logic       shift_left_right,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       dir_q, dir_d;
    // Terminal count (N-1) latched at the handshake so N cannot change mid-sequence.
    logic [3:0] last_q, last_d;
    logic [3:0] last_sel;

`ifdef SHIFT_SEQ_CNT_EN
    always_comb begin
        if (shift_len == 4'd0 || shift_len > 4'd8) begin
            last_sel = 4'd7;
        end else begin
            last_sel = shift_len - 4'd1;
        end
    end
`else
    assign last_sel = 4'd7;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            byte_q  <= 8'h00;
            dir_q   <= 1'b0;
            last_q  <= 4'd7;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        dir_d   = dir_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (data_valid) begin
                    state_d = StLoad;
                    byte_d  = data_in;
                    dir_d   = dir_in;
                    last_d  = last_sel;
                end
            end
            StLoad: begin
                state_d = StShift;
                cnt_d   = 4'd0;
            end
            StShift: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == last_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Idle and done both park the downstream register with a continuous load of zero.
    always_comb begin
        data_ready       = 1'b0;
        load_enable      = 1'b1;
        i                = 8'h00;
        shift_left_right = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        unique case (state_q)
            StIdle: begin
                data_ready = 1'b1;
            end
            StLoad: begin
                i                = byte_q;
                shift_left_right = dir_q;
                busy             = 1'b1;
            end
            StShift: begin
                load_enable      = 1'b0;
                i                = byte_q;
                shift_left_right = dir_q;
                busy             = 1'b1;
            end
            StDone: begin
                shift_left_right = dir_q;
                busy             = 1'b1;
                done             = 1'b1;
            end
            default: begin
                data_ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a queue-of-expected-cycles model plus directed literal checks.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       dir_in;
    logic       data_ready;
    logic [7:0] i;
    logic       load_enable;
    logic       shift_left_right;
    logic       busy;
    logic       done;
`ifdef SHIFT_SEQ_CNT_EN
    logic [3:0] shift_len;
`endif

    int total = 0;
    int bad   = 0;

    shift_seq_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .data_in          (data_in),
        .data_valid       (data_valid),
        .dir_in           (dir_in),
`ifdef SHIFT_SEQ_CNT_EN
        .shift_len        (shift_len),
`endif
        .data_ready       (data_ready),
        .i                (i),
        .load_enable      (load_enable),
        .shift_left_right (shift_left_right),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // Downstream shift register the controller is meant to drive.
    logic [7:0] q = 8'h00;
    always @(posedge clk) begin
        if (load_enable) q <= i;
        else if (shift_left_right) q <= q >> 1;
        else q <= q << 1;
    end

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endfunction

    // Packed view: {data_ready, load_enable, busy, done, shift_left_right, i}
    function automatic logic [12:0] pack(logic rdy, logic le, logic bsy, logic dn, logic d,
                                         logic [7:0] v);
        return {rdy, le, bsy, dn, d, v};
    endfunction

    localparam logic [12:0] IdleVec = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    function automatic int eff_len(logic [3:0] sl);
        if (sl == 4'd0 || sl > 4'd8) return 8;
        return int'(sl);
    endfunction

    // Model: every accepted byte schedules LOAD, N shifts and DONE; empty queue means idle.
    logic [12:0] exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (data_valid) begin
            int n;
`ifdef SHIFT_SEQ_CNT_EN
            n = eff_len(shift_len);
`else
            n = 8;
`endif
            exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, dir_in, data_in));
            for (int k = 0; k < n; k++)
                exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, dir_in, data_in));
            exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b1, dir_in, 8'h00));
        end
    end

    always @(negedge clk) begin
        logic [12:0] e;
        e = (exp_q.size() > 0) ? exp_q[0] : IdleVec;
        chk("outputs_vs_model",
            {19'd0, data_ready, load_enable, busy, done, shift_left_right, i}, {19'd0, e});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_hs(input logic [7:0] b, input logic d);
        data_in    = b;
        dir_in     = d;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    // Called while in LOAD; runs until busy drops (bounded).
    task automatic observe(output int nbusy, output int nshift, output int ndone,
                           output int nslr, output int nqzero);
        nbusy = 0; nshift = 0; ndone = 0; nslr = 0; nqzero = 0;
        for (int k = 0; k < 30; k++) begin
            if (!busy) break;
            nbusy++;
            if (!load_enable) nshift++;
            if (shift_left_right) nslr++;
            if (done) begin
                ndone++;
                if (q == 8'h00) nqzero++;
            end
            tick();
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            tick();
        end
        chk("wait_idle_bound", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_idle(string name);
        chk(name, {19'd0, data_ready, load_enable, busy, done, shift_left_right, i},
            {19'd0, IdleVec});
    endtask

    initial begin
        int nb, ns, nd, nl, nz;
        reset      = 1'b1;
        data_in    = 8'h00;
        data_valid = 1'b0;
        dir_in     = 1'b0;
`ifdef SHIFT_SEQ_CNT_EN
        shift_len  = 4'd8;
`endif
        tick();
        tick();
        chk_idle("reset_idle");
        reset = 1'b0;

        // Left sequence of 8'hFF.
        drive_hs(8'hFF, 1'b0);
        chk("left_load_i", {24'd0, i}, 32'hFF);
        chk("left_load_le", {31'd0, load_enable}, 32'd1);
        observe(nb, ns, nd, nl, nz);
        chk("left_busy_cycles", nb, 10);
        chk("left_shift_cycles", ns, 8);
        chk("left_done_pulses", nd, 1);
        chk("left_dir_cycles", nl, 1 - 1);
        chk("left_q_zero_at_done", nz, 1);
        chk_idle("left_back_idle");

        // Right sequence of 8'hA8.
        tick();
        drive_hs(8'hA8, 1'b1);
        observe(nb, ns, nd, nl, nz);
        chk("right_busy_cycles", nb, 10);
        chk("right_dir_cycles", nl, 10);
        chk("right_q_zero_at_done", nz, 1);

        // Offers during SHIFT must be ignored.
        tick();
        drive_hs(8'hA8, 1'b1);
        tick();
        data_valid = 1'b1;
        data_in    = 8'h55;
        dir_in     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ignore_i", {24'd0, i}, 32'hA8);
            chk("ignore_ready", {31'd0, data_ready}, 32'd0);
            chk("ignore_dir", {31'd0, shift_left_right}, 32'd1);
        end
        data_valid = 1'b0;
        wait_idle();

        // Offer held high: accepted on the edge leaving the single idle cycle.
        data_in    = 8'h81;
        dir_in     = 1'b0;
        data_valid = 1'b1;
        tick();
        for (int k = 0; k < 30; k++) begin
            if (done) break;
            tick();
        end
        chk("b2b_done_seen", {31'd0, done}, 32'd1);
        tick();
        chk("b2b_idle_gap", {31'd0, data_ready}, 32'd1);
        tick();
        chk("b2b_reload", {22'd0, busy, load_enable, i}, {22'd0, 1'b1, 1'b1, 8'h81});
        data_valid = 1'b0;
        wait_idle();

        // Abort on the 4th SHIFT cycle.
        drive_hs(8'hC3, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        chk("abort_in_shift", {31'd0, load_enable}, 32'd0);
        reset = 1'b1;
        #1;
        chk_idle("abort_immediate_idle");
        tick();
        chk_idle("abort_held_idle");
        reset      = 1'b0;
        data_in    = 8'h3C;
        dir_in     = 1'b0;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("abort_new_load", {23'd0, busy, i}, {23'd0, 1'b1, 8'h3C});
        observe(nb, ns, nd, nl, nz);
        chk("abort_new_busy", nb, 10);
        chk("abort_new_done", nd, 1);

`ifdef SHIFT_SEQ_CNT_EN
        tick();
        shift_len = 4'd3;
        drive_hs(8'h0F, 1'b0);
        observe(nb, ns, nd, nl, nz);
        chk("len3_shifts", ns, 3);
        tick();
        shift_len = 4'd0;
        drive_hs(8'h0F, 1'b0);
        observe(nb, ns, nd, nl, nz);
        chk("len0_shifts", ns, 8);
        tick();
        shift_len = 4'd12;
        drive_hs(8'h0F, 1'b0);
        observe(nb, ns, nd, nl, nz);
        chk("len12_shifts", ns, 8);
        tick();
        shift_len = 4'd3;
        drive_hs(8'h0F, 1'b1);
        shift_len = 4'd7;
        observe(nb, ns, nd, nl, nz);
        chk("len_change_mid", ns, 3);
`endif

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 800; k++) begin
            data_valid = ($urandom_range(0, 2) == 0);
            data_in    = 8'($urandom);
            dir_in     = 1'($urandom);
`ifdef SHIFT_SEQ_CNT_EN
            shift_len  = 4'($urandom);
`endif
            reset      = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset      = 1'b0;
        data_valid = 1'b0;
        wait_idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
